srl_fifo_flow_ctrl: RTL and testbench
=====================================

// Module: srl_fifo_flow_ctrl
// PURPOSE
// - Parametrised SRL-based FIFO for HLS dataflow channels: the shift-register storage plus pointer, flags and occupancy.
// - Sits between producer and consumer PE processes in the linear-layer kernels.
// - Adds occupancy count, programmable almost-full/almost-empty flags and an optional registered output stage.
// PARAMETERS
// - DATA_WIDTH  32  payload bits per entry
// - DEPTH       16  storage entries (>=2)
// - ADDR_WIDTH  $clog2(DEPTH)  read-address bits into storage
// - AF_LEVEL    DEPTH-2  if_almost_full_n deasserts when usedw >= AF_LEVEL
// - AE_LEVEL    2  if_almost_empty_n deasserts when usedw <= AE_LEVEL
// PORTS
// - ap_clk             in   1             clock, all logic rising edge
// - ap_rst_n           in   1             asynchronous reset, active low
// - if_write_ce        in   1             write-side clock enable
// - if_write           in   1             write request
// - if_din             in   DATA_WIDTH    write data
// - if_full_n          out  1             1 = space available
// - if_almost_full_n   out  1             0 = usedw >= AF_LEVEL
// - if_read_ce         in   1             read-side clock enable
// - if_read            in   1             read request (pop)
// - if_dout            out  DATA_WIDTH    head-of-FIFO data (show-ahead)
// - if_empty_n         out  1             1 = if_dout valid
// - if_almost_empty_n  out  1             0 = usedw <= AE_LEVEL
// - usedw              out  ADDR_WIDTH+2  entries held (incl. output stage if present)
// BEHAVIOUR
// - push = if_write & if_write_ce & if_full_n; pop = if_read & if_read_ce & if_empty_n.
// - Storage: on push all entries shift up one, din enters slot 0; contents are never reset.
// - Read address rd_addr = oldest entry = (storage count - 1); dout = storage[rd_addr].
// - push only: count+1; pop only: count-1; push & pop: count unchanged, rd_addr unchanged.
// - Full: if_full_n=0 when count==DEPTH; writes then ignored, even with a same-cycle pop (no write-through).
// - Empty: if_empty_n=0 when count==0; reads ignored; push on empty -> if_empty_n=1 next cycle.
// - Flags and usedw are registered, updated on the same edge as count; no combinational in->out paths.
// - Latency: write at edge N -> data on if_dout and if_empty_n=1 after edge N (1 cycle).
// - Reset (async assert, sync-release use): count=0, usedw=0, rd_addr=0, if_full_n=1, if_empty_n=0,
//   if_almost_full_n=1, if_almost_empty_n=0, if_dout undefined-but-stable (X allowed in storage path).
// - Reset mid-operation: all queued data discarded; first push after release behaves as on empty.
// - AF_LEVEL>DEPTH or AE_LEVEL>=DEPTH: flag constant (never/always asserted); elaboration warning only.
// CONFIGURATION
// - SRL_FIFO_OUT_REG_EN defined: registered output stage after storage; if_dout driven from flop.
//   Stage auto-refills from storage when empty or popped; capacity DEPTH+1; usedw counts the stage.
//   First-word latency 2 cycles (push at N -> if_empty_n=1 after edge N+1); output reg reset: valid=0, data=0.
// - Undefined: combinational dout from storage as above; capacity DEPTH; latency 1.
// STRUCTURE
// - Package srl_fifo_pkg: clog2 helper, AF/AE default-level functions, occupancy width constant.
// - Sub-module srl_fifo_storage: parametrised shift register (we, addr, din, dout), no reset.
// - Top holds control: count/rd_addr FSM-free counters, flag registers, optional output stage.
// TESTING
// - Reset: hold ap_rst_n=0 with writes active -> full_n=1, empty_n=0, usedw=0; no state change.
// - Fill DEPTH=16 with 0..15 -> full_n=0 after 16th push, almost_full_n=0 at usedw=14; 17th write dropped.
// - Drain 16 -> dout sequence 0..15 in order, empty_n=0 after last pop, almost_empty_n=0 at usedw=2.
// - Simultaneous push/pop at usedw=5 for 100 cycles -> usedw stays 5, data order preserved.
// - Push/pop gated by if_write_ce=0 / if_read_ce=0 -> no count or data change.
// - Reset asserted at usedw=9 -> flags return to reset values same cycle; next push yields dout=new data.
// - With SRL_FIFO_OUT_REG_EN: single push at N -> empty_n=1 after N+1; fill reports full at usedw=17.

Source files
------------

// File: rtl/srl_fifo_pkg.sv
// Shared constants, types and helpers for the SRL FIFO channel.
// Used by srl_fifo_storage and srl_fifo_flow_ctrl (SRL_FIFO_OUT_REG_EN selects the output stage).
package srl_fifo_pkg;

  // usedw is two bits wider than the read address: it must reach DEPTH (+1 with output stage).
  localparam int unsigned OCC_EXTRA_BITS = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned srl_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int af_default_level(input int depth);
    return depth - 2;
  endfunction

  function automatic int ae_default_level();
    return 2;
  endfunction

endpackage

// File: rtl/srl_fifo_storage.sv
// Shift-register storage: on write every entry moves up one slot and din enters slot 0.
// Contents are intentionally unreset so the array maps onto SRL primitives.
module srl_fifo_storage
  import srl_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = srl_clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[0] <= din_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/srl_fifo_flow_ctrl.sv
// SRL FIFO for dataflow channels: occupancy, full/empty and almost-full/almost-empty flags.
// Define SRL_FIFO_OUT_REG_EN to add a registered output stage (capacity DEPTH+1, latency 2).
module srl_fifo_flow_ctrl
  import srl_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = srl_clog2(DEPTH),
  parameter int unsigned AF_LEVEL   = af_default_level(DEPTH),
  parameter int unsigned AE_LEVEL   = ae_default_level()
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  if_almost_empty_n,
  output logic [ADDR_WIDTH+1:0] usedw
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned UW = ADDR_WIDTH + OCC_EXTRA_BITS;

  logic                  push;
  logic                  pop;
  logic                  stor_rd;
  fifo_op_e              op;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  full_n_q, af_n_q, ae_n_q;
  logic [UW-1:0]         usedw_q, usedw_d;
  logic                  af_hit, ae_hit;
  logic [DATA_WIDTH-1:0] stor_dout;

  // Full gates writes even when a pop happens in the same cycle: no write-through.
  assign push = if_write & if_write_ce & full_n_q;
  assign op   = fifo_op_e'({push, stor_rd});

  always_comb begin
    count_d = count_q;
    case (op)
      OP_PUSH: count_d = count_q + CW'(1);
      OP_POP:  count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    rd_addr_d = (count_d == '0) ? '0 : ADDR_WIDTH'(count_d - CW'(1));
  end

  srl_fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_storage (
    .clk_i  (ap_clk),
    .we_i   (push),
    .addr_i (rd_addr_q),
    .din_i  (if_din),
    .dout_o (stor_dout)
  );

`ifdef SRL_FIFO_OUT_REG_EN
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] dout_q;

  // Stage refills from storage whenever it is empty or being popped this cycle.
  assign pop     = if_read & if_read_ce & valid_q;
  assign stor_rd = (count_q != '0) & (~valid_q | pop);
  assign valid_d = stor_rd | (valid_q & ~pop);
  assign usedw_d = UW'(count_d) + UW'(valid_d);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (stor_rd) dout_q <= stor_dout;
    end
  end

  assign if_dout    = dout_q;
  assign if_empty_n = valid_q;
`else
  logic empty_n_q;

  assign pop     = if_read & if_read_ce & empty_n_q;
  assign stor_rd = pop;
  assign usedw_d = UW'(count_d);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) empty_n_q <= 1'b0;
    else           empty_n_q <= (count_d != '0);
  end

  assign if_dout    = stor_dout;
  assign if_empty_n = empty_n_q;
`endif

  if (AF_LEVEL > DEPTH) begin : g_af_off
    $warning("srl_fifo_flow_ctrl: AF_LEVEL > DEPTH, almost-full never asserted");
    assign af_hit = 1'b0;
  end else begin : g_af_on
    assign af_hit = (usedw_d >= UW'(AF_LEVEL));
  end

  if (AE_LEVEL >= DEPTH) begin : g_ae_on
    $warning("srl_fifo_flow_ctrl: AE_LEVEL >= DEPTH, almost-empty always asserted");
    assign ae_hit = 1'b1;
  end else begin : g_ae_cmp
    assign ae_hit = (usedw_d <= UW'(AE_LEVEL));
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count_q   <= '0;
      rd_addr_q <= '0;
      full_n_q  <= 1'b1;
      af_n_q    <= 1'b1;
      ae_n_q    <= 1'b0;
      usedw_q   <= '0;
    end else begin
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      full_n_q  <= (count_d != CW'(DEPTH));
      af_n_q    <= ~af_hit;
      ae_n_q    <= ~ae_hit;
      usedw_q   <= usedw_d;
    end
  end

  assign if_full_n         = full_n_q;
  assign if_almost_full_n  = af_n_q;
  assign if_almost_empty_n = ae_n_q;
  assign usedw             = usedw_q;

endmodule

// File: tb/tb_srl_fifo_flow_ctrl.sv
// Randomized self-checking bench for srl_fifo_flow_ctrl (default build, no output stage),
// compared cycle by cycle against a queue-based reference model.
module tb_srl_fifo_flow_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          ap_clk;
  logic          ap_rst_n;
  logic          if_write_ce;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_full_n;
  logic          if_almost_full_n;
  logic          if_read_ce;
  logic          if_read;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic          if_almost_empty_n;
  logic [5:0]    usedw;

  int n_checks;
  int n_errors;
  logic [DW-1:0] model_q[$];

  srl_fifo_flow_ctrl #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .ap_clk            (ap_clk),
    .ap_rst_n          (ap_rst_n),
    .if_write_ce       (if_write_ce),
    .if_write          (if_write),
    .if_din            (if_din),
    .if_full_n         (if_full_n),
    .if_almost_full_n  (if_almost_full_n),
    .if_read_ce        (if_read_ce),
    .if_read           (if_read),
    .if_dout           (if_dout),
    .if_empty_n        (if_empty_n),
    .if_almost_empty_n (if_almost_empty_n),
    .usedw             (usedw)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic check_reset_flags(input string tag);
    check_eq({tag, "_full_n"},  64'(if_full_n),         64'd1);
    check_eq({tag, "_empty_n"}, 64'(if_empty_n),        64'd0);
    check_eq({tag, "_usedw"},   64'(usedw),             64'd0);
    check_eq({tag, "_af_n"},    64'(if_almost_full_n),  64'd1);
    check_eq({tag, "_ae_n"},    64'(if_almost_empty_n), 64'd0);
  endtask

  task automatic check_model();
    int n;
    n = model_q.size();
    check_eq("full_n",  64'(if_full_n),         64'(n != DEPTH));
    check_eq("empty_n", 64'(if_empty_n),        64'(n != 0));
    check_eq("usedw",   64'(usedw),             64'(n));
    check_eq("af_n",    64'(if_almost_full_n),  64'(!(n >= AF)));
    check_eq("ae_n",    64'(if_almost_empty_n), 64'(!(n <= AE)));
    if (n != 0) check_eq("dout", 64'(if_dout), 64'(model_q[0]));
  endtask

  // One clock: drive inputs, predict from the model's own occupancy, compare after the edge.
  task automatic step(input logic wr, input logic wce, input logic [DW-1:0] d,
                      input logic rd, input logic rce);
    bit m_push, m_pop;
    if_write    = wr;
    if_write_ce = wce;
    if_din      = d;
    if_read     = rd;
    if_read_ce  = rce;
    m_push = wr && wce && (model_q.size() < DEPTH);
    m_pop  = rd && rce && (model_q.size() != 0);
    @(posedge ap_clk);
    if (m_pop)  void'(model_q.pop_front());
    if (m_push) model_q.push_back(d);
    #1;
    check_model();
  endtask

  task automatic drain_all();
    for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++) step(1'b0, 1'b1, '0, 1'b1, 1'b1);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    ap_rst_n    = 1'b1;
    if_write_ce = 1'b0;
    if_write    = 1'b0;
    if_din      = '0;
    if_read_ce  = 1'b0;
    if_read     = 1'b0;
    #1;
    ap_rst_n = 1'b0;

    // Reset held with writes and reads active: nothing may change.
    if_write = 1'b1; if_write_ce = 1'b1; if_read = 1'b1; if_read_ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_din = $urandom;
      @(posedge ap_clk);
      #1;
      check_reset_flags("rst_hold");
    end
    if_write = 1'b0; if_read = 1'b0;
    ap_rst_n = 1'b1;

    // Fill with 0..15, then a 17th write that must be dropped.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, DW'(i), 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    // Full plus simultaneous pop: write still refused.
    step(1'b1, 1'b1, 32'hBAD0_0001, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b1);

    drain_all();
    step(1'b0, 1'b1, '0, 1'b1, 1'b1);

    // Steady push/pop at occupancy 5.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, $urandom, 1'b1, 1'b1);

    // Clock-enable gating.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'($urandom_range(0, 1)), 1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0);

    // Random traffic: write-biased, then read-biased, then balanced.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 9), $urandom,
           1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 8));
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 8), $urandom,
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 9));
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 8), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 8));

    // Asynchronous reset at occupancy 9.
    drain_all();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b1);
    if_write = 1'b0; if_read = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    model_q.delete();
    #1;
    check_reset_flags("rst_async");
    @(posedge ap_clk);
    #1;
    check_reset_flags("rst_async_edge");
    ap_rst_n = 1'b1;
    step(1'b1, 1'b1, 32'hCAFE_0123, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b1, 1'b1);
    for (int i = 0; i < 50; i++)
      step(1'($urandom_range(0, 1)), 1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
